// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: trigger/config/output bundle for pulse_stretch_mc.
//   in       raw trigger inputs, one per channel
//   width    pulse length in cycles, shared by all channels (0 behaves as 1)
//   retrig   1 = trigger during an active pulse restarts it
//   edge_md  1 = rising-edge triggering, 0 = level triggering
//   out      stretched pulses, one per channel
//   busy     OR of out
//   drop_clr / drop   present only with PULSE_STRETCH_DROP_EN defined:
//            sticky per-channel flags for ignored triggers, and their clear
// Modports: master drives triggers/config, slave is the stretcher.
interface pulse_stretch_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0] in;
    logic [CNT_W-1:0]    width;
    logic                retrig;
    logic                edge_md;
    logic [CHANNELS-1:0] out;
    logic                busy;
`ifdef PULSE_STRETCH_DROP_EN
    logic                drop_clr;
    logic [CHANNELS-1:0] drop;
`endif

    modport master (
        output in, width, retrig, edge_md,
`ifdef PULSE_STRETCH_DROP_EN
        output drop_clr,
        input  drop,
`endif
        input  out, busy
    );

    modport slave (
        input  in, width, retrig, edge_md,
`ifdef PULSE_STRETCH_DROP_EN
        input  drop_clr,
        output drop,
`endif
        output out, busy
    );
endinterface

// File: rtl/pulse_stretch_mc.sv
// pulse_stretch_mc: multi-channel, run-time configurable pulse stretcher.
// Each channel owns a down-counter; an accepted trigger loads it with the
// effective width and the channel output stays high while it is non-zero.
// Ports:
//   clk   single clock, all logic on posedge
//   rst   synchronous, active-high reset
//   bus   pulse_stretch_if.slave (in, width, retrig, edge_md -> out, busy)
// Optional feature: define PULSE_STRETCH_DROP_EN to add sticky per-channel
// drop flags (bus.drop) that record triggers ignored while a pulse was active,
// cleared by bus.drop_clr.
module pulse_stretch_mc #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    pulse_stretch_if.slave  bus
);
    typedef logic [CNT_W-1:0] cnt_t;

    logic [CHANNELS-1:0] in_d_q, in_d_d;
    cnt_t                cnt_q [CHANNELS];
    cnt_t                cnt_d [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic                busy_q, busy_d;
    logic [CHANNELS-1:0] trig;
    cnt_t                w_eff;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_eff  = (bus.width == '0) ? cnt_t'(1) : bus.width;
        in_d_d = bus.in;
        trig   = '0;
        out_d  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = '0;
            trig[c]  = bus.edge_md ? (bus.in[c] & ~in_d_q[c]) : bus.in[c];
            // Accept when idle, or when reloading is allowed mid-pulse.
            if (trig[c] && ((cnt_q[c] == '0) || bus.retrig)) begin
                cnt_d[c] = w_eff;
            end else if (cnt_q[c] != '0) begin
                cnt_d[c] = cnt_q[c] - cnt_t'(1);
            end
            // out is registered from the next count so it rises on the
            // same edge that loads the counter.
            out_d[c] = (cnt_d[c] != '0);
        end
        busy_d = |out_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values computed before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_d_q <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            // NOTE: the counter array is reset explicitly; it defines the
            // output, so a mid-pulse reset must clear it.
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            in_d_q <= in_d_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;

`ifdef PULSE_STRETCH_DROP_EN
    logic [CHANNELS-1:0] drop_q, drop_d;
    logic [CHANNELS-1:0] ignored;

    always_comb begin
        ignored = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ignored[c] = trig[c] & (cnt_q[c] != '0) & ~bus.retrig;
        end
        // A same-cycle ignored trigger wins over the clear.
        drop_d = (drop_q & ~{CHANNELS{bus.drop_clr}}) | ignored;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop = drop_q;
`endif
endmodule
